// File: rtl/decode_queue.sv
// Registered instruction decoder feeding a DEPTH-entry FIFO of decoded entries.
// Each entry carries opcode/register/immediate/type fields, an illegal flag and its PC tag.
module decode_queue #(
    parameter int DATA_W       = 16,
    parameter int PC_W         = 16,
    parameter int DEPTH        = 4,
    parameter int SIGN_EXT_IMM = 1,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_opcode,
    output logic [3:0]        out_rdst,
    output logic [3:0]        out_rsrc,
    output logic [DATA_W-1:0] out_imm,
    output logic [3:0]        out_flag_type,
    output logic              out_illegal,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] TYPE_WAIT    = 4'b0000;
    localparam logic [3:0] TYPE_R       = 4'b0001;
    localparam logic [3:0] TYPE_I       = 4'b0010;
    localparam logic [3:0] TYPE_LOAD    = 4'b0100;
    localparam logic [3:0] TYPE_STORE   = 4'b0101;
    localparam logic [3:0] TYPE_JUMP    = 4'b1000;
    localparam logic [3:0] TYPE_BRANCH  = 4'b1100;
    localparam logic [3:0] TYPE_ILLEGAL = 4'b1111;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [3:0]        rdst;
        logic [3:0]        rsrc;
        logic [DATA_W-1:0] imm;
        logic [3:0]        ftype;
        logic              illegal;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [AW:0]       r_wrPtr;
    logic [AW:0]       r_rdPtr;
    logic [AW:0]       r_count;
    logic [CNT_W-1:0]  r_illegalCnt;

    entry_t            w_dec;
    entry_t            w_head;
    logic [DATA_W-1:0] w_immSext;
    logic [DATA_W-1:0] w_immZext;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_immSext = DATA_W'($signed(in_instr[7:0]));
    assign w_immZext = DATA_W'(in_instr[7:0]);

    // The I-type nibble match takes priority over the full opcode byte table.
    always_comb begin
        w_dec     = '0;
        w_dec.pc  = in_pc;
        if (in_instr[15:12] == 4'h5 || in_instr[15:12] == 4'h9) begin
            w_dec.opcode = {4'h0, in_instr[15:12]};
            w_dec.rdst   = in_instr[11:8];
            w_dec.imm    = (SIGN_EXT_IMM != 0) ? w_immSext : w_immZext;
            w_dec.ftype  = TYPE_I;
        end else begin
            w_dec.opcode = in_instr[15:8];
            case (in_instr[15:8])
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: begin
                    w_dec.rdst  = in_instr[7:4];
                    w_dec.rsrc  = in_instr[3:0];
                    w_dec.ftype = TYPE_R;
                end
                8'h85: begin
                    w_dec.rdst  = in_instr[7:4];
                    w_dec.rsrc  = in_instr[3:0];
                    w_dec.ftype = TYPE_LOAD;
                end
                8'h87: begin
                    w_dec.rdst  = in_instr[7:4];
                    w_dec.rsrc  = in_instr[3:0];
                    w_dec.ftype = TYPE_STORE;
                end
                8'h00: begin
                    w_dec.ftype = TYPE_WAIT;
                end
                8'h40, 8'h41, 8'h46, 8'h47: begin
                    w_dec.rdst  = in_instr[11:8];
                    w_dec.imm   = w_immSext;
                    w_dec.ftype = TYPE_JUMP;
                end
                8'hC0, 8'hC1, 8'hC6, 8'hC7: begin
                    w_dec.rdst  = in_instr[11:8];
                    w_dec.imm   = w_immSext;
                    w_dec.ftype = TYPE_BRANCH;
                end
                default: begin
                    w_dec.ftype   = TYPE_ILLEGAL;
                    w_dec.illegal = 1'b1;
                end
            endcase
        end
    end

    assign w_full    = (r_count == FULL_COUNT);
    assign in_ready  = !reset && !w_full && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr[AW-1:0]] <= w_dec;
                r_wrPtr <= r_wrPtr + ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of accepted illegal encodings; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegalCnt <= '0;
        end else if (w_push && w_dec.illegal && r_illegalCnt != '1) begin
            r_illegalCnt <= r_illegalCnt + CNT_ONE;
        end
    end

    assign w_head = out_valid ? r_mem[r_rdPtr[AW-1:0]] : '0;

    assign out_opcode    = w_head.opcode;
    assign out_rdst      = w_head.rdst;
    assign out_rsrc      = w_head.rsrc;
    assign out_imm       = w_head.imm;
    assign out_flag_type = w_head.ftype;
    assign out_illegal   = w_head.illegal;
    assign out_pc        = w_head.pc;
    assign illegal_count = r_illegalCnt;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: table vectors, hand-written corner sequences and random traffic
// checked against a queue-based reference model; a second instance covers zero-extension and CNT_W=2.
module tb_decode_queue;

    localparam int DATA_W = 16;
    localparam int PC_W   = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              flush;
    logic              inValid;
    logic [15:0]       inInstr;
    logic [PC_W-1:0]   inPc;
    logic              outReady;

    logic              inReady, outValid, outIllegal;
    logic [7:0]        outOpcode;
    logic [3:0]        outRdst, outRsrc, outType;
    logic [DATA_W-1:0] outImm;
    logic [PC_W-1:0]   outPc;
    logic [CNT_W-1:0]  illegalCount;

    logic              inReady2, outValid2, outIllegal2;
    logic [7:0]        outOpcode2;
    logic [3:0]        outRdst2, outRsrc2, outType2;
    logic [DATA_W-1:0] outImm2;
    logic [PC_W-1:0]   outPc2;
    logic [1:0]        illegalCount2;

    decode_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .SIGN_EXT_IMM(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReady),
        .in_instr(inInstr), .in_pc(inPc), .out_valid(outValid), .out_ready(outReady),
        .out_opcode(outOpcode), .out_rdst(outRdst), .out_rsrc(outRsrc), .out_imm(outImm),
        .out_flag_type(outType), .out_illegal(outIllegal), .out_pc(outPc),
        .illegal_count(illegalCount)
    );

    decode_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .SIGN_EXT_IMM(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReady2),
        .in_instr(inInstr), .in_pc(inPc), .out_valid(outValid2), .out_ready(outReady),
        .out_opcode(outOpcode2), .out_rdst(outRdst2), .out_rsrc(outRsrc2), .out_imm(outImm2),
        .out_flag_type(outType2), .out_illegal(outIllegal2), .out_pc(outPc2),
        .illegal_count(illegalCount2)
    );

    typedef struct {
        logic [7:0]  opcode;
        logic [3:0]  rdst;
        logic [3:0]  rsrc;
        logic [15:0] immS;
        logic [15:0] immZ;
        logic [3:0]  ftype;
        logic        illegal;
        logic [15:0] pc;
    } entry_t;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  opcode;
        logic [3:0]  rdst;
        logic [3:0]  rsrc;
        logic [15:0] immS;
        logic [15:0] immZ;
        logic [3:0]  ftype;
        logic        illegal;
    } vec_t;

    entry_t modelQ[$];
    int     modelCnt  = 0;
    int     modelCnt2 = 0;
    int     checks    = 0;
    int     errors    = 0;

    // Reference decode written from the instruction-set rules, one class at a time.
    function automatic entry_t refDecode(logic [15:0] instr, logic [15:0] pc);
        entry_t      e;
        logic [7:0]  op;
        logic [3:0]  hi;
        logic [15:0] low;
        logic [15:0] sext;
        e    = '{default: '0};
        e.pc = pc;
        op   = instr[15:8];
        hi   = instr[15:12];
        low  = {8'h00, instr[7:0]};
        sext = instr[7] ? (16'hFF00 + low) : low;
        if (hi == 4'h5 || hi == 4'h9) begin
            e.opcode = {4'h0, hi};
            e.rdst   = instr[11:8];
            e.immS   = sext;
            e.immZ   = low;
            e.ftype  = 4'b0010;
        end else begin
            e.opcode = op;
            if (op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                           8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84, 8'h85, 8'h87}) begin
                e.rdst  = instr[7:4];
                e.rsrc  = instr[3:0];
                e.ftype = (op == 8'h85) ? 4'b0100 : (op == 8'h87) ? 4'b0101 : 4'b0001;
            end else if (op == 8'h00) begin
                e.ftype = 4'b0000;
            end else if (op inside {8'h40, 8'h41, 8'h46, 8'h47, 8'hC0, 8'hC1, 8'hC6, 8'hC7}) begin
                e.rdst  = instr[11:8];
                e.immS  = sext;
                e.immZ  = sext;
                e.ftype = op[7] ? 4'b1100 : 4'b1000;
            end else begin
                e.ftype   = 4'b1111;
                e.illegal = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        entry_t e;
        logic   expValid;
        logic   expReady;
        expValid = (modelQ.size() != 0);
        expReady = (modelQ.size() < DEPTH) && !flush && !reset;
        e = expValid ? modelQ[0] : '{default: '0};
        checkVal("in_ready", 32'(inReady), 32'(expReady));
        checkVal("out_valid", 32'(outValid), 32'(expValid));
        checkVal("out_opcode", 32'(outOpcode), 32'(e.opcode));
        checkVal("out_rdst", 32'(outRdst), 32'(e.rdst));
        checkVal("out_rsrc", 32'(outRsrc), 32'(e.rsrc));
        checkVal("out_imm", 32'(outImm), 32'(e.immS));
        checkVal("out_flag_type", 32'(outType), 32'(e.ftype));
        checkVal("out_illegal", 32'(outIllegal), 32'(e.illegal));
        checkVal("out_pc", 32'(outPc), 32'(e.pc));
        checkVal("illegal_count", 32'(illegalCount), 32'(modelCnt));
        checkVal("zext out_imm", 32'(outImm2), 32'(e.immZ));
        checkVal("cnt2 illegal_count", 32'(illegalCount2), 32'(modelCnt2));
    endtask

    // One clock of stimulus: drive, check mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                                 input logic ordy, input logic fl);
        logic   doPush;
        logic   doPop;
        entry_t e;
        inValid  = iv;
        inInstr  = instr;
        inPc     = pc;
        outReady = ordy;
        flush    = fl;
        @(negedge clk);
        checkOutput();
        doPush = iv && !fl && (modelQ.size() < DEPTH);
        doPop  = ordy && !fl && (modelQ.size() != 0);
        e = refDecode(instr, pc);
        @(posedge clk);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doPush) begin
                modelQ.push_back(e);
                if (e.illegal) begin
                    if (modelCnt < 255) modelCnt++;
                    if (modelCnt2 < 3) modelCnt2++;
                end
            end
        end
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, " out_valid"}, 32'(outValid), 32'd0);
        checkVal({tag, " in_ready"}, 32'(inReady), 32'd0);
        checkVal({tag, " illegal_count"}, 32'(illegalCount), 32'd0);
        checkVal({tag, " cnt2"}, 32'(illegalCount2), 32'd0);
        checkVal({tag, " opcode"}, 32'(outOpcode), 32'd0);
        checkVal({tag, " imm"}, 32'(outImm), 32'd0);
        checkVal({tag, " type"}, 32'(outType), 32'd0);
        checkVal({tag, " illegal"}, 32'(outIllegal), 32'd0);
    endtask

    vec_t vecs[13];
    logic [7:0] opPool[12];

    initial begin
        vecs[0]  = '{16'h5A7F, 8'h05, 4'hA, 4'h0, 16'h007F, 16'h007F, 4'b0010, 1'b0};
        vecs[1]  = '{16'h9380, 8'h09, 4'h3, 4'h0, 16'hFF80, 16'h0080, 4'b0010, 1'b0};
        vecs[2]  = '{16'h0553, 8'h05, 4'h5, 4'h3, 16'h0000, 16'h0000, 4'b0001, 1'b0};
        vecs[3]  = '{16'hC1FE, 8'hC1, 4'h1, 4'h0, 16'hFFFE, 16'hFFFE, 4'b1100, 1'b0};
        vecs[4]  = '{16'h8574, 8'h85, 4'h7, 4'h4, 16'h0000, 16'h0000, 4'b0100, 1'b0};
        vecs[5]  = '{16'h0A12, 8'h0A, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'b1111, 1'b1};
        vecs[6]  = '{16'hFF00, 8'hFF, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'b1111, 1'b1};
        vecs[7]  = '{16'h8712, 8'h87, 4'h1, 4'h2, 16'h0000, 16'h0000, 4'b0101, 1'b0};
        vecs[8]  = '{16'h0000, 8'h00, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 1'b0};
        vecs[9]  = '{16'h4702, 8'h47, 4'h7, 4'h0, 16'h0002, 16'h0002, 4'b1000, 1'b0};
        vecs[10] = '{16'h84AB, 8'h84, 4'hA, 4'hB, 16'h0000, 16'h0000, 4'b0001, 1'b0};
        vecs[11] = '{16'h0E34, 8'h0E, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'b1111, 1'b1};
        vecs[12] = '{16'h1234, 8'h12, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'b1111, 1'b1};
        opPool = '{8'h01, 8'h0B, 8'h84, 8'h85, 8'h87, 8'h00, 8'h46, 8'hC7, 8'h5C, 8'h93, 8'h0D, 8'hF1};

        reset = 1'b1; flush = 1'b0; inValid = 1'b0; inInstr = '0; inPc = '0; outReady = 1'b0;
        #1;
        checkResetState("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors: each pushed into an empty queue, checked one cycle later, then popped.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 16'h1000 + 16'(i * 2), 1'b0, 1'b0);
            checkVal("vec out_valid", 32'(outValid), 32'd1);
            checkVal("vec opcode", 32'(outOpcode), 32'(vecs[i].opcode));
            checkVal("vec rdst", 32'(outRdst), 32'(vecs[i].rdst));
            checkVal("vec rsrc", 32'(outRsrc), 32'(vecs[i].rsrc));
            checkVal("vec imm", 32'(outImm), 32'(vecs[i].immS));
            checkVal("vec zext imm", 32'(outImm2), 32'(vecs[i].immZ));
            checkVal("vec type", 32'(outType), 32'(vecs[i].ftype));
            checkVal("vec illegal", 32'(outIllegal), 32'(vecs[i].illegal));
            checkVal("vec pc", 32'(outPc), 32'(16'h1000 + 16'(i * 2)));
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        end
        checkVal("illegal_count after table", 32'(illegalCount), 32'd4);
        checkVal("cnt2 saturated", 32'(illegalCount2), 32'd3);

        // Fill with out_ready low: only DEPTH pushes land.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(k), 16'h2000 + 16'(k), 1'b0, 1'b0);
        end
        checkVal("full in_ready", 32'(inReady), 32'd0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checkVal("ready after pop", 32'(inReady), 32'd1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checkVal("drained out_valid", 32'(outValid), 32'd0);

        // Two entries deep, then simultaneous push/pop across pointer wrap.
        applyStimulus(1'b1, 16'h0211, 16'h3000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0322, 16'h3001, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 16'h0500 + 16'(k), 16'h3002 + 16'(k), 1'b1, 1'b0);
        end
        checkVal("steady head pc", 32'(outPc), 32'h3008);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Flush at occupancy 3 while an illegal instruction is offered.
        applyStimulus(1'b1, 16'h0A12, 16'h4000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0553, 16'h4001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8574, 16'h4002, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hFF00, 16'h4003, 1'b0, 1'b1);
        checkVal("flush out_valid", 32'(outValid), 32'd0);
        checkVal("flush keeps count", 32'(illegalCount), 32'd5);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [15:0] instr;
            logic [7:0]  op;
            if ($urandom_range(0, 3) == 0) begin
                instr = 16'($urandom);
            end else begin
                op    = opPool[$urandom_range(0, 11)];
                instr = {op, 8'($urandom)};
            end
            applyStimulus($urandom_range(0, 3) != 0, instr, 16'($urandom),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset between clock edges with entries queued.
        applyStimulus(1'b1, 16'h0A55, 16'h5000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0166, 16'h5001, 1'b0, 1'b0);
        inValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkResetState("mid reset");
        modelQ.delete();
        modelCnt  = 0;
        modelCnt2 = 0;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'hC6F0, 16'h6000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised successor to the combinational instruction decoder. It accepts 16-bit instructions over a valid/ready handshake and decodes each one into opcode, register, immediate and type fields. Decoded entries are held in a DEPTH-entry FIFO in front of the execute stage. It also adds a subi I-type, illegal-opcode detection, immediate extension to datapath width, PC tagging, flush, and a saturating illegal-instruction counter.

## Interface
- DATA_W, 16, width of the extended immediate (≥ 8)
- PC_W, 16, width of the PC tag carried with each instruction
- DEPTH, 4, FIFO entries (power of 2, ≥ 2)
- SIGN_EXT_IMM, 1, 1 = sign-extend I-type immediates, 0 = zero-extend
- CNT_W, 8, width of the illegal counter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous queue clear
- in_valid  in  1  instruction offered
- in_ready  out  1  decoder can accept
- in_instr  in  16  raw instruction
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes the head entry
- out_opcode  out  8  decoded opcode
- out_rdst  out  4  destination register, or condition code for jumps/branches
- out_rsrc  out  4  source register
- out_imm  out  DATA_W  extended immediate/displacement
- out_flag_type  out  4  type code
- out_illegal  out  1  entry is an undefined encoding
- out_pc  out  PC_W  PC tag of the entry
- illegal_count  out  CNT_W  accepted illegal instructions, saturating

## Operation
- **Type codes:** R 0001, I 0010, load 0100, store 0101, jump 1000, branch 1100, wait 0000, illegal 1111.
- **Decode priority:**
  - First match on in_instr[15:12]. 0101 (addi) or 1001 (subi) is I-type.
  - An I-type instruction decodes as: opcode = {4'h0, [15:12]}, rdst = [11:8], rsrc = 0, imm = [7:0] extended per SIGN_EXT_IMM.
- **Otherwise, match the opcode byte [15:8]:**
  - **R-type** 0x01 AND, 0x02 OR, 0x03 XOR, 0x04 NOT, 0x05 ADD, 0x06 ADDU, 0x07 ADDC, 0x08 RSH, 0x09 SUB, 0x0B CMP, 0x0C ALSH, 0x0F ARSH, 0x84 LSH: rdst = [7:4], rsrc = [3:0], imm = 0.
  - **Memory**, same fields as R-type: 0x85 is load (type 0100), 0x87 is store (type 0101).
  - **Wait** 0x00: rdst = rsrc = imm = 0, type 0000.
  - **Jump** 0x40/0x41/0x46/0x47 and **branch** 0xC0/0xC1/0xC6/0xC7: rdst = [11:8] (condition EQ/NE/GT/LE), rsrc = 0, imm = [7:0] always sign-extended.
  - **Any other byte** is illegal: opcode = [15:8], rdst = rsrc = imm = 0, type 1111, out_illegal = 1.
- **No X values:** no output is ever driven X; unused fields are 0.
- **FIFO:**
  - Decode happens at push. The FIFO stores the decoded fields, out_illegal and the PC tag.
  - in_ready = !full && !flush.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - Pointers have log2(DEPTH)+1 bits and wrap modulo DEPTH. An occupancy counter runs 0..DEPTH.
  - Push and pop in the same cycle leave occupancy unchanged. This is legal at any non-full, non-empty occupancy. When empty, the push goes through and there is no pop.
  - Outputs come from the head register. out_valid = (occupancy != 0).
- **Flush:** occupancy and pointers return to 0 on the next edge. No push and no pop take effect in the flush cycle. illegal_count is unaffected.
- **illegal_count:** increments on each push of an illegal encoding. It saturates at 2^CNT_W-1 and is cleared only by reset.

## Timing
- **Reset:** asynchronous, clears occupancy, pointers and illegal_count immediately.
  - While reset is high: out_valid = 0, in_ready = 0.
  - Head fields read 0, with out_flag_type = 0000 and out_illegal = 0.
- **After reset:** in_ready rises in the first cycle after reset deasserts.
- **Latency:** 1 cycle. A push at edge N into an empty FIFO gives out_valid = 1 with the decoded fields after edge N.
- **Throughput:** 1 instruction per cycle sustained while out_ready = 1.
- **Full:** in_ready is low when occupancy = DEPTH. It rises in the cycle after a pop. in_ready has no combinational path from out_ready.
- **Output stability:** while out_valid && !out_ready, all out_* stay stable.
- **Reset mid-operation:** all queued entries are discarded, with no partial pop.

## Test plan
- **I-type extension:** push 0x5A7F, then 0x9380, with SIGN_EXT_IMM = 1 and DATA_W = 16. Expect (opcode 0x05, rdst A, imm 0x007F, type 0010), then (opcode 0x09, rdst 3, imm 0xFF80). With SIGN_EXT_IMM = 0, 0x9380 gives imm 0x0080.
- **R-type, branch, load:** push 0x0553, 0xC1FE, 0x8574.
  - Expect (0x05, rdst 5, rsrc 3, type 0001), then (0xC1, rdst 1, imm 0xFFFE, type 1100), then (0x85, rdst 7, rsrc 4, type 0100).
  - out_pc matches each in_pc.
- **Illegal:** push 0x0A12, then 0xFF00. Expect out_illegal = 1, type 1111, opcodes 0x0A and 0xFF, illegal_count 0→2. With CNT_W = 2, five illegal pushes leave the count at 3.
- **Full/empty:** DEPTH = 4, out_ready = 0, in_valid held high.
  - Exactly 4 pushes occur, then in_ready = 0.
  - Raising out_ready for 1 cycle pops the first entry, and in_ready returns the next cycle.
  - Draining all entries preserves order and gives out_valid = 0.
- **Simultaneous push/pop:** at occupancy 2 with in_valid = out_ready = 1 for 8 cycles, occupancy stays 2 and order is preserved across pointer wrap-around.
- **Flush and reset:**
  - Flush at occupancy 3 with in_valid = 1: out_valid = 0 the next cycle, the input offered in the flush cycle is not accepted, and illegal_count is kept.
  - Reset asserted mid-stream between clock edges: out_valid, in_ready and illegal_count go to 0 immediately.
